// File: rtl/fifo_drain_if.sv
// fifo_drain_if: sfifo read port plus downstream valid/ready stream of fifo_drain
// master: the drain block (pops sfifo, drives out_*); slave: the sfifo and downstream sink
interface fifo_drain_if #(
  parameter int WIDTH = 8,
  parameter int CNT_BITS = 4
);
  logic fifo_empty;
  logic [CNT_BITS:0] fifo_counter;
  logic [WIDTH-1:0] fifo_data;
  logic fifo_read_n;
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master (
    input fifo_empty, fifo_counter, fifo_data, out_ready,
    output fifo_read_n, out_data, out_valid
  );
  modport slave (
    output fifo_empty, fifo_counter, fifo_data, out_ready,
    input fifo_read_n, out_data, out_valid
  );
endinterface

// File: rtl/fifo_drain.sv
// fifo_drain: drains an sfifo in threshold-sized bursts or fully on flush into a 2-entry valid/ready output buffer
// clock/reset: rising-edge clock, synchronous active-high reset
// enable/flush/threshold: burst permission, full-drain request, burst trigger level and length
// bus: sfifo pop port (fifo_*) and downstream stream (out_*); busy: not IDLE; words_sent: wrapping transfer count
module fifo_drain #(
  parameter int WIDTH = 8,
  parameter int CNT_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                flush,
  input  logic [CNT_BITS:0]   threshold,
  fifo_drain_if.master        bus,
  output logic                busy,
  output logic [15:0]         words_sent
);
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, WAIT} state_t;
  state_t state;
  logic pending, rd_ptr, wr_ptr, pop, xfer;
  logic [1:0] buf_count;
  logic [2:0] occ;
  logic [CNT_BITS:0] burst;
  logic [WIDTH-1:0] buf_mem [2];
  assign xfer = bus.out_valid & bus.out_ready;
  // occupancy the buffer will have after this edge; a pop is safe only if a slot remains for its data next cycle
  assign occ = {1'b0, buf_count} + {2'b0, pending} - {2'b0, xfer};
  assign pop = !reset && (state == DRAIN || state == FLUSH) && !bus.fifo_empty && occ < 3'd2;
  assign bus.fifo_read_n = !pop;
  assign bus.out_valid = buf_count != 2'd0;
  assign bus.out_data = buf_mem[rd_ptr];
  assign busy = state != IDLE;
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      pending <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      buf_count <= 2'd0;
      burst <= '0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      words_sent <= '0;
    end else begin
      pending <= pop;
      buf_count <= occ[1:0];
      words_sent <= words_sent + {15'd0, xfer};
      rd_ptr <= rd_ptr ^ xfer;
      wr_ptr <= wr_ptr ^ pending;
      if (pending) buf_mem[wr_ptr] <= bus.fifo_data;
      case (state)
        IDLE:
          if (flush) state <= FLUSH;
          else if (enable && threshold != '0 && bus.fifo_counter >= threshold) begin
            state <= DRAIN;
            burst <= threshold;
          end
        DRAIN: begin
          burst <= burst - {{CNT_BITS{1'b0}}, pop};
          if (flush) begin
            state <= FLUSH;
            burst <= '0;
          end else if (!enable || (pop && burst == (CNT_BITS+1)'(1))) state <= WAIT;
        end
        FLUSH: if (bus.fifo_empty && !pop) state <= WAIT;
        WAIT: if (!pending && buf_count == 2'd0) state <= IDLE;
      endcase
    end
endmodule
